ifetch_unit: RTL

- Instruction-fetch stage of the single-cycle RV32 core. It holds the PC and fetches from instruction memory through a req/ready handshake that tolerates variable latency.
- It presents one instruction at a time to decode/ALU. When that instruction retires, it computes the next PC from the ALU's branch flag (`zero`), the ALU result (jalr target) and `imm32`.
- It flags misaligned or out-of-range targets and counts retired instructions.

---
 rtl/ifetch_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready port,
// holds one instruction until it retires, then steers to the next PC.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch,
  input  logic        zero,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] imm32,
  input  logic [31:0] alu_result,
  input  logic        hold,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        inst_valid,
  output logic        fetch_err,
  output logic [31:0] instret
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) << 2;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    TRAP  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] rel_target;
  logic [31:0] jalr_target;
  logic [31:0] next_pc;
  logic        target_bad;

  assign pc_plus4    = pc + 32'd4;
  assign rel_target  = pc + imm32;
  assign jalr_target = alu_result & 32'hFFFF_FFFE;

  always_comb begin
    next_pc = pc_plus4;
    priority case (1'b1)
      jalr:           next_pc = jalr_target;
      jal:            next_pc = rel_target;
      branch && zero: next_pc = rel_target;
      default:        next_pc = pc_plus4;
    endcase
  end

  // Compare in 33 bits so a full 4 GiB memory never wraps the limit.
  assign target_bad = (next_pc[1:0] != 2'b00) ||
                      ({1'b0, next_pc} >= PC_LIMIT);

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      inst       <= NOP;
      inst_valid <= 1'b0;
      fetch_err  <= 1'b0;
      instret    <= 32'd0;
    end else begin
      unique case (state)
        FETCH: begin
          if (imem_ready) begin
            inst       <= imem_rdata;
            inst_valid <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (!hold) begin
            instret    <= instret + 32'd1;
            pc         <= next_pc;
            inst_valid <= 1'b0;
            if (target_bad) begin
              fetch_err <= 1'b1;
              state     <= TRAP;
            end else begin
              state <= FETCH;
            end
          end
        end
        TRAP: begin
          inst_valid <= 1'b0;
          fetch_err  <= 1'b1;
        end
        default: begin
          inst_valid <= 1'b0;
          fetch_err  <= 1'b1;
          state      <= TRAP;
        end
      endcase
    end
  end

endmodule
